fetch_unit: RTL and testbench

Instruction fetch stage of the 5-stage RISC-V pipeline. Owns the program counter and issues requests to the instruction memory, with one request outstanding at a time and variable response latency. It produces InstrF/PCF/PCPlus4F for the IF/ID pipeline register. It honours stall (StallF) and branch/jump redirect (PCSrcE/PCTargetE), and emits a NOP bubble whenever no valid instruction is available.

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/fetch_buffer.sv | 30 +++
 rtl/fetch_unit.sv | 154 +++++++++++++++
 tb/tb_fetch_unit.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared pipeline constants and fetch FSM state type
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FULL,
    DRAIN
  } fetch_state_t;

  // Instruction fetch is word-granular; the low address bits never reach memory.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - one-entry holding register for an instruction caught by a stall
module fetch_buffer
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            clear,
  input  logic [XLEN-1:0] instr_d,
  input  logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] instr_q,
  output logic [XLEN-1:0] pc_q,
  output logic            valid
);

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      valid   <= 1'b0;
    end else if (load) begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid   <= 1'b1;
    end else if (clear) begin
      valid   <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - IF stage: PC ownership, single-outstanding imem requests, stall and redirect
module fetch_unit
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            StallF,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] InstrF,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] PCPlus4F,
  output logic            FetchValidF
);

  fetch_state_t    state, state_n;
  logic [XLEN-1:0] pc_q, pc_n;
  logic [XLEN-1:0] req_pc, req_pc_n;

  logic            buf_load, buf_clear, buf_valid;
  logic [XLEN-1:0] buf_instr, buf_pc;

  logic [XLEN-1:0] target;
  logic [XLEN-1:0] seq_pc;

  assign target = word_align(PCTargetE);
  assign seq_pc = req_pc + 32'd4;

  fetch_buffer u_buf (
    .clk     (clk),
    .reset   (reset),
    .load    (buf_load),
    .clear   (buf_clear),
    .instr_d (imem_rdata),
    .pc_d    (req_pc),
    .instr_q (buf_instr),
    .pc_q    (buf_pc),
    .valid   (buf_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      pc_q   <= RESET_PC;
      req_pc <= RESET_PC;
    end else begin
      state  <= state_n;
      pc_q   <= pc_n;
      req_pc <= req_pc_n;
    end
  end

  always_comb begin
    state_n     = state;
    pc_n        = pc_q;
    req_pc_n    = req_pc;
    buf_load    = 1'b0;
    buf_clear   = 1'b0;
    imem_req    = 1'b0;
    imem_addr   = pc_q;
    InstrF      = NOP_INSTR;
    PCF         = '0;
    FetchValidF = 1'b0;

    case (state)
      IDLE: begin
        if (PCSrcE) begin
          pc_n = target;
        end else begin
          imem_req = 1'b1;
          if (imem_ready) begin
            req_pc_n = pc_q;
            state_n  = WAIT;
          end
        end
      end

      WAIT: begin
        if (!imem_rvalid) begin
          if (PCSrcE) begin
            pc_n    = target;
            state_n = DRAIN;
          end
        end else if (PCSrcE) begin
          pc_n    = target;
          state_n = IDLE;
        end else if (!StallF) begin
          // Pass-through and back-to-back request keep a 1-cycle memory at full rate.
          InstrF      = imem_rdata;
          PCF         = req_pc;
          FetchValidF = 1'b1;
          imem_req    = 1'b1;
          imem_addr   = seq_pc;
          if (imem_ready) begin
            req_pc_n = seq_pc;
          end else begin
            pc_n    = seq_pc;
            state_n = IDLE;
          end
        end else begin
          InstrF      = imem_rdata;
          PCF         = req_pc;
          FetchValidF = 1'b1;
          buf_load    = 1'b1;
          state_n     = FULL;
        end
      end

      FULL: begin
        InstrF      = buf_instr;
        PCF         = buf_pc;
        FetchValidF = buf_valid;
        if (PCSrcE) begin
          buf_clear = 1'b1;
          pc_n      = target;
          state_n   = IDLE;
        end else if (!StallF) begin
          buf_clear = 1'b1;
          pc_n      = buf_pc + 32'd4;
          state_n   = IDLE;
        end
      end

      DRAIN: begin
        if (PCSrcE) begin
          pc_n = target;
        end
        if (imem_rvalid) begin
          state_n = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase

    // Outputs are combinational in IDLE/WAIT, so reset must mask them explicitly.
    if (reset) begin
      imem_req    = 1'b0;
      InstrF      = NOP_INSTR;
      PCF         = '0;
      FetchValidF = 1'b0;
      buf_load    = 1'b0;
      buf_clear   = 1'b0;
    end
  end

  assign PCPlus4F = FetchValidF ? (PCF + 32'd4) : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench with program-order scoreboard and variable-latency imem model
module tb_fetch_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        StallF = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'hDEAD_BEEF;
  logic [31:0] InstrF, PCF, PCPlus4F;
  logic        FetchValidF;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int mem_lat = 1;

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .StallF      (StallF),
    .PCSrcE      (PCSrcE),
    .PCTargetE   (PCTargetE),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .InstrF      (InstrF),
    .PCF         (PCF),
    .PCPlus4F    (PCPlus4F),
    .FetchValidF (FetchValidF)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, {31'b0, act}, {31'b0, exp});
  endtask

  // Memory: one response exactly mem_lat cycles after the accepted request; shares reset.
  initial begin : imem_model
    logic        xfer, rst, pend;
    logic [31:0] paddr;
    int          cnt;
    pend = 1'b0; cnt = 0; paddr = '0;
    forever begin
      @(negedge clk);
      rst  = reset;
      xfer = !reset && imem_req && imem_ready;
      if (xfer) begin
        pend  = 1'b1;
        cnt   = mem_lat;
        paddr = imem_addr;
      end
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
      if (rst) pend = 1'b0;
      else if (pend) begin
        cnt--;
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(paddr);
          pend        = 1'b0;
        end
      end
    end
  end

  // Scoreboard: instructions reach IF/ID in program order, each exactly once.
  initial begin : scoreboard
    logic [31:0] exp_pc, last_req, pend_tgt;
    logic        pend_redir, xfer, consumed;
    int          outst;
    exp_pc = RESET_PC; last_req = '0; pend_tgt = RESET_PC; pend_redir = 1'b1; outst = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        check1("rst_req", imem_req, 1'b0);
        check1("rst_valid", FetchValidF, 1'b0);
        check("rst_instr", InstrF, NOP_INSTR);
        check("rst_pcs", PCF | PCPlus4F, 32'h0);
        exp_pc = RESET_PC; pend_tgt = RESET_PC; pend_redir = 1'b1; outst = 0;
        continue;
      end
      if (FetchValidF) begin
        check("instr_of_pc", InstrF, mem_word(PCF));
        check("pcplus4", PCPlus4F, PCF + 32'd4);
      end else begin
        check("bubble_instr", InstrF, NOP_INSTR);
        check("bubble_pcs", PCF | PCPlus4F, 32'h0);
      end
      consumed = FetchValidF && !StallF && !PCSrcE;
      if (consumed) begin
        check("program_order", PCF, exp_pc);
        exp_pc = exp_pc + 32'd4;
      end
      if (PCSrcE) check1("no_req_on_redirect", imem_req, 1'b0);
      if (imem_req) check1("one_outstanding", (outst == 0) || imem_rvalid, 1'b1);
      xfer = imem_req && imem_ready;
      if (imem_rvalid && outst > 0) outst--;
      if (xfer) begin
        check("req_addr", imem_addr, pend_redir ? pend_tgt : last_req + 32'd4);
        last_req   = imem_addr;
        pend_redir = 1'b0;
        outst++;
      end
      if (PCSrcE) begin
        exp_pc     = {PCTargetE[31:2], 2'b00};
        pend_tgt   = exp_pc;
        pend_redir = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic next();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic restart(input int lat);
    reset = 1'b1; StallF = 1'b0; PCSrcE = 1'b0; imem_ready = 1'b1; mem_lat = lat;
    next();
    next();
    reset = 1'b0;
    #3;
  endtask

  task automatic wait_valid_pc(input logic [31:0] pc, input string name);
    logic found;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      next();
      #3;
      if (FetchValidF && PCF == pc) found = 1'b1;
    end
    check1(name, found, 1'b1);
  endtask

  task automatic wait_any_valid(input string name);
    logic found;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      next();
      #3;
      if (FetchValidF) found = 1'b1;
    end
    check1(name, found, 1'b1);
  endtask

  logic [31:0] rdy_pat   = 32'b1011_0111_1101_1110_0111_1011_1101_0110;
  logic [31:0] stall_pat = 32'b0001_1000_0110_0000_1110_0001_0000_1100;

  initial begin : stimulus
    int          prev_cyc;
    logic [31:0] prev_pc;
    int          n;

    // Reset release with a 1-cycle memory: back-to-back fetches 0, 4, 8.
    next(); #3;
    check1("t1_reset_req", imem_req, 1'b0);
    check("t1_reset_instr", InstrF, 32'h0000_0013);
    next(); reset = 1'b0; #3;
    check1("t1_req0", imem_req, 1'b1);
    check("t1_addr0", imem_addr, 32'h0);
    next(); #3;
    check1("t1_valid0", FetchValidF, 1'b1);
    check("t1_pc0", PCF, 32'h0);
    check("t1_addr1", imem_addr, 32'h4);
    next(); #3;
    check("t1_pc1", PCF, 32'h4);
    check("t1_addr2", imem_addr, 32'h8);
    next(); #3;
    check("t1_pc2", PCF, 32'h8);
    check1("t1_valid2", FetchValidF, 1'b1);

    // 3-cycle memory: valid every 3rd cycle, sequential PCs.
    mem_lat = 3;
    wait_any_valid("t2_first");
    prev_cyc = cyc; prev_pc = PCF;
    for (int k = 0; k < 3; k++) begin
      wait_any_valid("t2_next");
      check("t2_gap", 32'(cyc - prev_cyc), 32'd3);
      check("t2_seq_pc", PCF, prev_pc + 32'd4);
      prev_cyc = cyc; prev_pc = PCF;
    end

    // Stall while the response for 0x10 arrives.
    restart(1);
    wait_valid_pc(32'hC, "t3_reach_c");
    next(); StallF = 1'b1; #3;
    check("t3_hold_pc_a", PCF, 32'h10);
    check("t3_hold_instr_a", InstrF, mem_word(32'h10));
    for (int k = 0; k < 2; k++) begin
      next(); #3;
      check("t3_hold_pc", PCF, 32'h10);
      check1("t3_hold_valid", FetchValidF, 1'b1);
      check1("t3_no_req", imem_req, 1'b0);
    end
    next(); StallF = 1'b0; #3;
    check("t3_consume_pc", PCF, 32'h10);
    check1("t3_consume_noreq", imem_req, 1'b0);
    next(); #3;
    check1("t3_req14", imem_req, 1'b1);
    check("t3_addr14", imem_addr, 32'h14);
    wait_valid_pc(32'h14, "t3_got14");

    // Redirect while 0x8 is outstanding: stale response dropped, target fetched next.
    restart(3);
    wait_valid_pc(32'h4, "t4_reach4");
    next(); PCSrcE = 1'b1; PCTargetE = 32'h200; #3;
    check1("t4_noreq", imem_req, 1'b0);
    next(); PCSrcE = 1'b0; #3;
    n = 0;
    while (!imem_rvalid && n < 10) begin
      next(); #3;
      n++;
    end
    check1("t4_stale_seen", imem_rvalid, 1'b1);
    check1("t4_stale_bubble", FetchValidF, 1'b0);
    next(); #3;
    check1("t4_req_tgt", imem_req, 1'b1);
    check("t4_addr_tgt", imem_addr, 32'h200);
    wait_valid_pc(32'h200, "t4_got200");

    // Redirect and stall together in FULL; misaligned target bits are dropped.
    restart(1);
    wait_valid_pc(32'h4, "t5_reach4");
    next(); StallF = 1'b1; #3;
    check("t5_captured", PCF, 32'h8);
    next(); PCSrcE = 1'b1; PCTargetE = 32'h303; #3;
    next(); PCSrcE = 1'b0; StallF = 1'b0; #3;
    check1("t5_req", imem_req, 1'b1);
    check("t5_addr", imem_addr, 32'h300);
    wait_valid_pc(32'h300, "t5_got300");

    // Reset while a request is outstanding.
    restart(3);
    next(); reset = 1'b1; #3;
    check1("t6_rst_req", imem_req, 1'b0);
    check1("t6_rst_valid", FetchValidF, 1'b0);
    check("t6_rst_instr", InstrF, 32'h0000_0013);
    next(); reset = 1'b0; #3;
    check1("t6_req", imem_req, 1'b1);
    check("t6_addr", imem_addr, 32'h0);
    wait_valid_pc(32'h0, "t6_got0");

    // PC wrap at the top of the address space.
    restart(1);
    wait_valid_pc(32'h4, "t7_reach4");
    next(); PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC; #3;
    next(); PCSrcE = 1'b0; #3;
    wait_valid_pc(32'hFFFF_FFFC, "t7_top");
    check("t7_wrap_plus4", PCPlus4F, 32'h0);
    wait_valid_pc(32'h0, "t7_wrapped");

    // Mixed ready/stall/redirect pattern, checked by the scoreboard.
    restart(2);
    for (int i = 0; i < 96; i++) begin
      next();
      imem_ready = rdy_pat[i % 32];
      StallF     = stall_pat[(i * 3) % 32];
      PCSrcE     = (i == 20) || (i == 41) || (i == 42) || (i == 77);
      PCTargetE  = 32'(256 + i * 16 + 1);
      #3;
    end
    next(); imem_ready = 1'b1; StallF = 1'b0; PCSrcE = 1'b0; #3;
    wait_any_valid("t8_live");

    next(); #3;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
